// File: rtl/mpsub256_serial.sv
// Digit-serial multi-precision subtractor: d_out = {0,a} - {0,b}, one W-bit digit per cycle.
// Shares the write/start/ready handshake of mpadd256_serial.
module mpsub256_serial #(
    parameter int N = 256,
    parameter int W = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         write,
    input  logic         start,
    output logic [N:0]   d_out,
    output logic         ready
);

    localparam int D  = N / W;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            borrow_q, borrow_d;
    logic [N:0]      d_out_q, d_out_d;
    logic            ready_q, ready_d;

    logic [W:0]      diff;
    logic            last;

    // Low digit of each operand minus incoming borrow; bit W is the outgoing borrow.
    assign diff = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]} - {{W{1'b0}}, borrow_q};
    assign last = (cnt_q == CW'(D - 1));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !write) state_d = BUSY;
            BUSY:    if (last)            state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        d_out_d  = d_out_q;
        ready_d  = ready_q;
        case (state_q)
            IDLE: begin
                if (write) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    ready_d = 1'b0;
                end else if (start) begin
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    ready_d  = 1'b0;
                end
            end
            BUSY: begin
                // Digits enter at the MSB end so digit 0 lands at the bottom after D shifts.
                acc_d    = N'({diff[W-1:0], acc_q} >> W);
                a_d      = a_q >> W;
                b_d      = b_q >> W;
                borrow_d = diff[W];
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    d_out_d = {diff[W], acc_d};
                    ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            d_out_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            d_out_q  <= d_out_d;
            ready_q  <= ready_d;
        end
    end

    assign d_out = d_out_q;
    assign ready = ready_q;

endmodule

// File: doc/mpsub256_serial.md
# mpsub256_serial

Multi-precision 256-bit serial subtractor. It computes `d_out = {1'b0,a} − {1'b0,b}` as a 257-bit two's-complement result, one W-bit digit per cycle, with the borrow carried between digits. It is the inverse companion of `mpadd256_serial` and presents the same `write`/`start`/`ready` handshake, so the same controller and bench harness drive both. It is used by the FFT datapath's multi-precision stage wherever differences are needed.

## Interface
- `N`, 256: operand width in bits.
- `W`, 64: digit width per cycle. N must be a multiple of W; digit count D = N/W (4 by default).
- `CLK` in 1: single clock. All logic is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `a_in` in N: minuend. Sampled only when `write` is accepted.
- `b_in` in N: subtrahend. Sampled only when `write` is accepted.
- `write` in 1: load request for both operands.
- `start` in 1: begin a subtraction on the latched operands.
- `d_out` out N+1: result. Bit N is the final borrow, equal to 1 when a < b. Bits N−1:0 are (a−b) mod 2^N.
- `ready` out 1: result valid. Goes high on completion and stays high until the next accepted `write` or `start`.

## Operation
- States: IDLE, BUSY.
- **Reset** (RST=1 at an edge): state←IDLE, operand registers←0, digit counter←0, borrow←0, `d_out`←0, `ready`←0. Reset overrides everything, including an operation in progress.
- **IDLE with `write`=1**: latch `a_in`/`b_in` into the operand shift registers and clear `ready`. `d_out` is unchanged.
- **IDLE with `start`=1 and `write`=0**: state←BUSY, counter←0, borrow←0, clear `ready`.
- **IDLE with `write`=1 and `start`=1 in the same cycle**: `write` wins and `start` is ignored.
- **BUSY, each cycle**:
  - Compute {borrow', digit} = a[W−1:0] − b[W−1:0] − borrow, as a (W+1)-bit subtraction.
  - Shift the digit into the internal result accumulator from the MSB side.
  - Shift both operand registers right by W. Register borrow'. Increment the counter.
- **BUSY, cycle with counter = D−1**:
  - `d_out` ← {borrow', final accumulator contents}.
  - `ready`←1, state←IDLE.
- **`write` or `start` while BUSY**: ignored. No operand change, no restart.
- `d_out` changes only on completion or reset. It holds the previous result throughout BUSY.
- A `start` without an intervening `write` recomputes using the operand registers as they stand. After a completed operation those registers have been shifted out and are 0, so the result is 0.

## Timing
- `write` sampled at edge k: operands are visible internally after edge k. `ready`=0 after edge k.
- `start` sampled at edge k: BUSY from edge k. Digit i is processed at edge k+1+i. `ready` and `d_out` are updated at edge k+D, which is edge k+4 by default.
- Latency from `start` to `ready` is D cycles. Minimum back-to-back period is write + start + D cycles = 6 cycles by default.
- `ready` is registered with no combinational path from inputs.
- Reset asserted during BUSY: the next edge returns the block to its reset state. `ready` stays 0 and the partial result is discarded.

## Test plan
- **Simple subtraction**: a=5, b=3, write, then start → after 4 cycles `ready`=1 and `d_out`=257'h2. `ready`=0 on each of the 4 BUSY cycles.
- **Negative result**: a=0, b=1 → `d_out` = 257 ones (bit 256=1, low bits all F).
- **Borrow across a digit boundary**: a=2^64, b=1 → `d_out` = 257'h0_..._0000000000000000FFFFFFFFFFFFFFFF. Also a=2^192, b=1 → bits 191:0 all ones, bits 256:192 zero.
- **Handshake robustness**:
  - Equal operands: a=b=0xDEAD…BEEF → `d_out`=0.
  - `start` and `write` pulsed at BUSY cycle 2 → ignored. Result is still correct at cycle 4.
  - `write`+`start` together in IDLE → operands load, no BUSY entry.
- **Reset mid-operation**: RST=1 at BUSY cycle 2 → next cycle `ready`=0, `d_out`=0, state IDLE. A following `start` without `write` yields `ready` after 4 cycles with `d_out`=0.
- **Random regression**: 1000 vector pairs from the two 256-bit LFSRs using the standard bench sequence (advance, write, start, wait `ready`) → `d_out` == {1'b0,a} − {1'b0,b} for every vector, error count 0.
